// File: rtl/rob_pkg.sv
// Shared reorder-buffer defaults and entry layout.
package rob_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;

  // One reorder-buffer slot at the default widths.
  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // Tag meaning "no producer"; tag 0 is also the post-reset tail.
  localparam logic [ROB_TAG_W-1:0] ROB_TAG_NONE = '0;
endpackage

// File: rtl/rob_lookup_port.sv
// Operand lookup by tag, with same-cycle bypass of the EX writeback.
module rob_lookup_port
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic [DEPTH-1:0]             busy,
  input  logic [DEPTH-1:0]             done,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic [TAG_W-1:0]             q_tag,
  output logic                         q_ready,
  output logic [DATA_W-1:0]            q_data
);
  logic hit;
  assign hit = wb_valid && (wb_tag == q_tag);

  // Free slots report nothing; a live writeback wins over stored data.
  always_comb begin
    q_ready = busy[q_tag] && (done[q_tag] || hit);
    q_data  = '0;
    if (busy[q_tag]) q_data = hit ? wb_data : data[q_tag];
  end
endmodule

// File: rtl/rob_tag_buffer.sv
// In-order tag allocator / reorder buffer: allocate at tail, writeback by
// tag, retire from head one entry per cycle.
module rob_tag_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count
);
  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t ent [DEPTH];
  logic [TAG_W-1:0] head, tail;

  logic [DEPTH-1:0]             busy_v, done_v;
  logic [DEPTH-1:0][DATA_W-1:0] data_v;
  logic do_alloc, do_wb, do_commit;

  assign alloc_ready = (count != (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready && !flush;
  assign do_wb       = wb_valid && !flush && ent[wb_tag].busy && !ent[wb_tag].done;
  assign do_commit   = ent[head].busy && ent[head].done && !flush;

  // Flatten entry fields for the lookup ports.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_v[i] = ent[i].busy;
      done_v[i] = ent[i].done;
      data_v[i] = ent[i].data;
    end
  end

  rob_lookup_port #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_q1 (
    .busy(busy_v), .done(done_v), .data(data_v),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .q_tag(q1_tag), .q_ready(q1_ready), .q_data(q1_data)
  );

  rob_lookup_port #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_q2 (
    .busy(busy_v), .done(done_v), .data(data_v),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .q_tag(q2_tag), .q_ready(q2_ready), .q_data(q2_data)
  );

  // Entry/pointer state; flush beats allocate, writeback and commit.
  // Alloc, writeback and commit never touch the same field of one slot:
  // alloc hits a free slot, writeback needs !done, commit needs done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].busy <= 1'b0;
        ent[i].done <= 1'b0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      if (do_commit) begin
        commit_rd      <= ent[head].rd;
        commit_data    <= ent[head].data;
        ent[head].busy <= 1'b0;
        ent[head].done <= 1'b0;
        head           <= head + 1'b1;
      end
      if (do_alloc) begin
        ent[tail].busy <= 1'b1;
        ent[tail].done <= 1'b0;
        ent[tail].rd   <= alloc_rd;
        tail           <= tail + 1'b1;
      end
      if (do_wb) begin
        ent[wb_tag].data <= wb_data;
        ent[wb_tag].done <= 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_tag_buffer.sv
// Bench for rob_tag_buffer: directed table, corner sequences, and random
// traffic checked against a queue-based program-order model.
module tb_rob_tag_buffer;
  localparam int D = 16;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic [3:0]  q1_tag = '0, q2_tag = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [4:0]  count;

  always #5 clk = ~clk;

  rob_tag_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .count(count)
  );

  // ---------------- reference model: in-flight list in program order
  typedef struct {
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          mhead;
  bit          m_cv;
  logic [4:0]  m_crd;
  logic [31:0] m_cd;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mhead = 0;
    m_cv  = 1'b0;
    m_crd = '0;
    m_cd  = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_clock();
    bit com, alloc_ok;
    int i;
    if (flush) begin
      mq.delete();
      mhead = 0;
      m_cv  = 1'b0;
    end else begin
      com      = (mq.size() > 0) && mq[0].done;
      alloc_ok = alloc_valid && (mq.size() < D);
      if (wb_valid) begin
        i = (int'(wb_tag) - mhead + D) % D;
        if (i < mq.size() && !mq[i].done) begin
          mq[i].done = 1'b1;
          mq[i].data = wb_data;
        end
      end
      m_cv = com;
      if (com) begin
        m_crd = mq[0].rd;
        m_cd  = mq[0].data;
        void'(mq.pop_front());
        mhead = (mhead + 1) % D;
      end
      if (alloc_ok) mq.push_back('{rd: alloc_rd, done: 1'b0, data: '0});
    end
  endtask

  task automatic lookup(input logic [3:0] t, output bit busy, output bit rdy, output logic [31:0] d);
    int  i;
    bit  hit;
    i    = (int'(t) - mhead + D) % D;
    hit  = wb_valid && (wb_tag == t);
    busy = i < mq.size();
    rdy  = busy && (mq[i].done || hit);
    d    = !busy ? 32'h0 : (hit ? wb_data : mq[i].data);
  endtask

  task automatic check_comb();
    bit b, r;
    logic [31:0] d;
    chk("alloc_ready", alloc_ready, mq.size() != D);
    chk("alloc_tag", alloc_tag, (mhead + mq.size()) % D);
    lookup(q1_tag, b, r, d);
    chk("q1_ready", q1_ready, r);
    if (!b || r) chk("q1_data", q1_data, d);
    lookup(q2_tag, b, r, d);
    chk("q2_ready", q2_ready, r);
    if (!b || r) chk("q2_data", q2_data, d);
  endtask

  task automatic check_regs();
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_rd", commit_rd, m_crd);
    chk("commit_data", commit_data, m_cd);
    chk("count", count, mq.size());
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic wv,
                       input logic [3:0] wt, input logic [31:0] wd, input logic fl,
                       input logic [3:0] t1, input logic [3:0] t2);
    alloc_valid = av; alloc_rd = ard;
    wb_valid = wv; wb_tag = wt; wb_data = wd;
    flush = fl; q1_tag = t1; q2_tag = t2;
  endtask

  task automatic comb_phase();
    #1;
    check_comb();
  endtask

  task automatic edge_phase();
    @(posedge clk);
    model_clock();
    #1;
    check_regs();
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic wv,
                      input logic [3:0] wt, input logic [31:0] wd, input logic fl);
    drive(av, ard, wv, wt, wd, fl, 4'd0, 4'd0);
    comb_phase();
    edge_phase();
  endtask

  // ---------------- directed table for the in-order commit scenario
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        wv;
    logic [3:0]  wt;
    logic [31:0] wd;
    logic [3:0]  e_tag;  // alloc_tag before the edge
    logic [4:0]  e_cnt;  // after the edge
    logic        e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cd;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [4:0]  rd_w;
    logic [31:0] d_w;
    logic [3:0]  wt;

    tv[0] = '{1, 5'd3, 0, 4'd0, 32'h0, 4'd0, 5'd1, 0, 5'd0, 32'h0};
    tv[1] = '{1, 5'd5, 0, 4'd0, 32'h0, 4'd1, 5'd2, 0, 5'd0, 32'h0};
    tv[2] = '{1, 5'd7, 0, 4'd0, 32'h0, 4'd2, 5'd3, 0, 5'd0, 32'h0};
    tv[3] = '{0, 5'd0, 1, 4'd1, 32'hB, 4'd3, 5'd3, 0, 5'd0, 32'h0};
    tv[4] = '{0, 5'd0, 0, 4'd0, 32'h0, 4'd3, 5'd3, 0, 5'd0, 32'h0};
    tv[5] = '{0, 5'd0, 1, 4'd0, 32'hA, 4'd3, 5'd3, 0, 5'd0, 32'h0};
    tv[6] = '{0, 5'd0, 0, 4'd0, 32'h0, 4'd3, 5'd2, 1, 5'd3, 32'hA};
    tv[7] = '{0, 5'd0, 0, 4'd0, 32'h0, 4'd3, 5'd1, 1, 5'd5, 32'hB};
    tv[8] = '{0, 5'd0, 0, 4'd0, 32'h0, 4'd3, 5'd1, 0, 5'd5, 32'hB};

    model_reset();
    #12 rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_data", commit_data, 0);

    // In-order retire with an out-of-order writeback.
    for (int k = 0; k < 9; k++) begin
      chk("t1_alloc_tag", alloc_tag, tv[k].e_tag);
      step(tv[k].av, tv[k].ard, tv[k].wv, tv[k].wt, tv[k].wd, 1'b0);
      chk("t1_count", count, tv[k].e_cnt);
      chk("t1_commit_valid", commit_valid, tv[k].e_cv);
      chk("t1_commit_rd", commit_rd, tv[k].e_crd);
      chk("t1_commit_data", commit_data, tv[k].e_cd);
    end

    // Fill to capacity, refused 17th alloc, then free one slot.
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < D; k++) step(1, 5'(k + 1), 0, 0, 0, 0);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    step(1, 5'd31, 0, 0, 0, 0);
    chk("full_count_17", count, 16);
    chk("full_tag_17", alloc_tag, 0);
    step(0, 0, 1, 4'd0, 32'h1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("full_commit_valid", commit_valid, 1);
    chk("full_commit_data", commit_data, 32'h1);
    chk("full_count_15", count, 15);
    chk("full_alloc_ready_again", alloc_ready, 1);

    // Bypass on a busy/not-done slot and a lookup of a free slot.
    drive(0, 0, 1, 4'd4, 32'hDEAD, 0, 4'd4, 4'd0);
    comb_phase();
    chk("byp_q1_ready", q1_ready, 1);
    chk("byp_q1_data", q1_data, 32'hDEAD);
    chk("free_q2_ready", q2_ready, 0);
    chk("free_q2_data", q2_data, 0);
    edge_phase();

    // Flush colliding with alloc, writeback and an eligible head.
    step(0, 0, 0, 0, 0, 1);
    step(1, 5'd1, 0, 0, 0, 0);
    step(1, 5'd2, 0, 0, 0, 0);
    step(1, 5'd3, 0, 0, 0, 0);
    step(0, 0, 1, 4'd0, 32'h55, 0);
    drive(1, 5'd9, 1, 4'd1, 32'h66, 1, 4'd0, 4'd0);
    comb_phase();
    edge_phase();
    chk("flush_count", count, 0);
    chk("flush_commit_valid", commit_valid, 0);
    chk("flush_alloc_tag", alloc_tag, 0);
    drive(0, 0, 1, 4'd2, 32'h77, 0, 4'd2, 4'd2);
    comb_phase();
    chk("flush_stale_q1_same", q1_ready, 0);
    edge_phase();
    drive(0, 0, 0, 0, 0, 0, 4'd2, 4'd0);
    comb_phase();
    chk("flush_stale_q1_after", q1_ready, 0);
    edge_phase();

    // Wrap-around stream: allocate, write back, retire.
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      rd_w = 5'($urandom);
      d_w  = $urandom;
      chk("wrap_tag", alloc_tag, k % D);
      step(1, rd_w, 0, 0, 0, 0);
      step(0, 0, 1, 4'(k % D), d_w, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("wrap_commit_valid", commit_valid, 1);
      chk("wrap_commit_rd", commit_rd, rd_w);
      chk("wrap_commit_data", commit_data, d_w);
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wt = 4'((mhead + $urandom_range(0, mq.size() - 1)) % D);
      else
        wt = 4'($urandom);
      drive($urandom_range(0, 2) != 0, 5'($urandom), $urandom_range(0, 1) == 1,
            wt, $urandom, $urandom_range(0, 49) == 0,
            ($urandom_range(0, 1) == 1) ? wt : 4'($urandom), 4'($urandom));
      comb_phase();
      edge_phase();
    end

    // Asynchronous reset between edges with five entries live.
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 5'(k), 0, 0, 0, 0);
    chk("pre_rst_count", count, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_alloc_ready", alloc_ready, 1);
    chk("async_rst_alloc_tag", alloc_tag, 0);
    chk("async_rst_commit_valid", commit_valid, 0);
    model_reset();
    #1 rst = 1'b0;
    step(1, 5'd4, 0, 0, 0, 0);
    chk("post_rst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_tag_buffer.md
Name: rob_tag_buffer

Overview:
Reorder buffer that owns instruction tags for the core pipeline. It hands out tags to ID in program order and accepts ALU results from EX by tag. It answers operand lookups for ID/EX and retires results to the register file strictly in order. It replaces the free-running tag counter currently feeding ID and is the responder side of the rob_info lookup used by EX.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2.
TAG_W, $clog2(DEPTH), tag width; must match `INST_TAG_WIDTH.
DATA_W, 32, result width.
REG_W, 5, architectural register index width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all in-flight entries (jump_ce from branch resolution)
alloc_valid  in  1  ID requests a new entry
alloc_rd  in  REG_W  destination register of the allocating instruction
alloc_ready  out  1  buffer can accept an allocation this cycle
alloc_tag  out  TAG_W  tag granted when alloc_valid && alloc_ready (equals tail)
wb_valid  in  1  EX result valid
wb_tag  in  TAG_W  tag of the EX result
wb_data  in  DATA_W  EX result value
q1_tag, q2_tag  in  TAG_W  operand lookup tags
q1_ready, q2_ready  out  1  entry busy and result available
q1_data, q2_data  out  DATA_W  result value for the lookup
commit_valid  out  1  one-cycle retire strobe, registered
commit_rd  out  REG_W  retired destination register
commit_data  out  DATA_W  retired value
count  out  TAG_W+1  occupied entries

Behaviour:
- Per-entry state: busy, done, rd, data. Pointers head and tail are TAG_W bits and wrap modulo DEPTH.
- Reset (async): head=0, tail=0, count=0, all busy/done=0, commit_valid=0, commit_rd=0, commit_data=0. Combinational outputs follow from state: alloc_ready=1, alloc_tag=0.
- alloc_ready = (count != DEPTH). It is purely state-based and does not look ahead to a same-cycle commit.
- Allocate (alloc_valid && alloc_ready && !flush) at posedge:
  - entry[tail].busy=1, done=0, rd=alloc_rd
  - tail = tail+1
- Writeback (wb_valid && !flush) at posedge:
  - Applies only if entry[wb_tag].busy=1 and done=0: data=wb_data, done=1.
  - Otherwise it is ignored. No error output.
- Commit at posedge, when entry[head].busy && entry[head].done && !flush:
  - commit_valid=1, commit_rd/commit_data from that entry
  - entry cleared, head = head+1
  - Otherwise commit_valid=0; commit_rd/commit_data hold.
- Throughput and latency:
  - At most one commit per cycle.
  - Minimum latency is writeback posedge to commit_valid high, 1 cycle.
- count: +1 on allocate, -1 on commit, unchanged if both occur in the same cycle.
- Same-cycle allocation into the slot just freed by commit is not supported; alloc_ready is low when count==DEPTH.
- Lookup (combinational):
  - qN_ready = busy[qN_tag] && (done[qN_tag] || (wb_valid && wb_tag==qN_tag)).
  - The bypass gives wb_data priority over stored data.
  - For a non-busy tag: ready=0, data=0.
- Flush at posedge has priority over allocate, writeback and commit in the same cycle:
  - all busy/done=0, head=tail=0, count=0, commit_valid=0
  - commit_rd and commit_data hold
- rd=0 entries commit normally; the register file discards writes to x0.
- Reset asserted mid-operation: immediate return to reset state, independent of clk.

Decomposition:
- Shared package rob_pkg holds:
  - DEPTH/TAG_W/DATA_W/REG_W defaults
  - rob_entry_t struct {busy, done, rd, data}
  - ROB_TAG_NONE constant
- Widths are tied to `INST_TAG_WIDTH in common_def.h.
- One natural sub-module, rob_lookup_port: the combinational lookup-with-bypass, instantiated twice.
- The rob_inf interface is later rebound to these lookup and commit signals.

Test Plan:
1. Reset, then allocate rd=3,5,7 back-to-back.
   - Required: tags 0,1,2; count=3.
   - wb tag1=0xB, then tag0=0xA: nothing commits until tag0 is written.
   - Then commits follow on consecutive cycles, (3,0xA) then (5,0xB).
   - Tag2 never written, so count=1 remains.
2. Fill all 16 entries.
   - Required: alloc_ready=0, and a 17th alloc_valid changes nothing.
   - Write tag0 (data 0x1): next cycle commit_valid=1, count=15.
   - Following cycle alloc_ready=1.
3. Wrap-around:
   - Stream 40 allocate/writeback/commit triples.
   - Required: commit order equals allocation order, tags wrap 15→0, and commit_data matches each tag's wb_data.
4. Lookup bypass:
   - Entry tag4 busy, not done; drive wb_tag=4, wb_data=0xDEAD and q1_tag=4 in the same cycle.
   - Required: q1_ready=1, q1_data=0xDEAD in that cycle.
   - Query of a free tag: ready=0, data=0.
5. Flush with alloc, wb and commit-eligible head all in one cycle.
   - Required next cycle: count=0, commit_valid=0, alloc_tag=0.
   - wb to old tag 2 afterwards is ignored (q reports ready=0).
6. Assert rst between clock edges with count=5.
   - Required: count=0 and alloc_ready=1 before the next posedge.
